// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants for the multicycle RV32I controller.
//   - 4-bit FSM state encoding
//   - opcode constants for the supported instruction classes
//   - ALUOp, ResultSrc, ALUSrcA/B and ALUControl codes
//   - imm_src(): opcode -> ImmSrc decode
package mc_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_FETCH    = 4'd0;
  localparam state_t ST_DECODE   = 4'd1;
  localparam state_t ST_MEMADR   = 4'd2;
  localparam state_t ST_MEMREAD  = 4'd3;
  localparam state_t ST_MEMWB    = 4'd4;
  localparam state_t ST_MEMWRITE = 4'd5;
  localparam state_t ST_EXECUTER = 4'd6;
  localparam state_t ST_EXECUTEI = 4'd7;
  localparam state_t ST_ALUWB    = 4'd8;
  localparam state_t ST_JAL      = 4'd9;
  localparam state_t ST_BEQ      = 4'd10;
  localparam state_t ST_HALT     = 4'd11;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    logic [1:0] r;
    case (op)
      OP_SW:   r = IMM_S;
      OP_BEQ:  r = IMM_B;
      OP_JAL:  r = IMM_J;
      default: r = IMM_I;  // lw, I-type ALU and anything unknown
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// mc_alu_decode: ALUOp/funct field decode to the datapath ALUControl code.
//   aluop      in   2  00 add, 01 sub, 10 decode by funct3
//   funct3     in   3  instruction funct3
//   funct7b5   in   1  instruction bit 30
//   op5        in   1  opcode bit 5 (1 = R-type, enables sub)
//   alucontrol out  3  ALU operation code
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALUC_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alucontrol = (op5 & funct7b5) ? ALUC_SUB : ALUC_ADD;  // addi never subtracts
          3'b010:  alucontrol = ALUC_SLT;
          3'b110:  alucontrol = ALUC_OR;
          3'b111:  alucontrol = ALUC_AND;
          default: alucontrol = ALUC_ADD;
        endcase
      end
      default: alucontrol = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a shared-memory multicycle RV32I
// datapath (lw, sw, R-type, I-type ALU, jal, beq).
// Parameter ILLEGAL_TRAP: 0 = unknown opcode returns to FETCH, 1 = enters HALT.
// Optional macro MC_MEM_WAIT_EN adds input mem_ready; FETCH, MEMREAD and
// MEMWRITE then hold until mem_ready = 1.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   op, funct3, funct7b5, Zero  instruction fields and ALU zero flag
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite,
//   ImmSrc, ALUControl          datapath controls
//   illegal_o                   pulse in DECODE on an unknown opcode
//   halted_o                    high while in HALT
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ILLEGAL_TRAP = 0
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef MC_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal_o,
  output logic       halted_o
);

  state_t     state_q, state_d;
  logic       ready;
  logic       pcupdate, branch, memwrite, irwrite, regwrite, illegal;
  logic [1:0] aluop;

`ifdef MC_MEM_WAIT_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pcupdate  = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    illegal   = 1'b0;
    halted_o  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    aluop     = ALUOP_ADD;
    case (state_q)
      ST_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        irwrite   = ready;
        pcupdate  = ready;
        if (ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        // ALU precomputes the branch target from OldPC + ImmExt
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYP:      state_d = ST_EXECUTER;
          OP_ITYP:      state_d = ST_EXECUTEI;
          OP_JAL:       state_d = ST_JAL;
          OP_BEQ:       state_d = ST_BEQ;
          default: begin
            illegal = 1'b1;
            state_d = (ILLEGAL_TRAP != 0) ? ST_HALT : ST_FETCH;
          end
        endcase
      end
      ST_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = op[5] ? ST_MEMWRITE : ST_MEMREAD;
      end
      ST_MEMREAD: begin
        AdrSrc = 1'b1;
        if (ready) state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        ResultSrc = RES_DATA;
        regwrite  = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_MEMWRITE: begin
        AdrSrc   = 1'b1;
        memwrite = 1'b1;
        if (ready) state_d = ST_FETCH;
      end
      ST_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        aluop   = ALUOP_FUNCT;
        state_d = ST_ALUWB;
      end
      ST_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
        state_d = ST_ALUWB;
      end
      ST_ALUWB: begin
        regwrite = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_JAL: begin
        // PC <= target held in ALUOut; ALU forms OldPC + 4 for the link
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        pcupdate = 1'b1;
        state_d  = ST_ALUWB;
      end
      ST_BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        halted_o = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Enables are gated by rst_n so nothing writes while reset is held,
  // even though the state already reads FETCH.
  assign PCWrite   = rst_n & (pcupdate | (branch & Zero));
  assign IRWrite   = rst_n & irwrite;
  assign MemWrite  = rst_n & memwrite;
  assign RegWrite  = rst_n & regwrite;
  assign illegal_o = rst_n & illegal;

  assign ImmSrc = imm_src(op);

  mc_alu_decode u_alu_decode (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alucontrol (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = RT;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b1;
  logic       zero = 1'b0;
`ifdef MC_MEM_WAIT_EN
  logic       mem_ready = 1'b1;
`endif

  logic pcw0, adr0, memw0, irw0, regw0, ill0, hlt0;
  logic [1:0] res0, sa0, sb0, imm0;
  logic [2:0] alu0;
  logic pcw1, adr1, memw1, irw1, regw1, ill1, hlt1;
  logic [1:0] res1, sa1, sb1, imm1;
  logic [2:0] alu1;
  logic [17:0] v0, v1;

  int total = 0;
  int bad = 0;

  assign v0 = {pcw0, adr0, memw0, irw0, res0, sa0, sb0, regw0, imm0, alu0, ill0, hlt0};
  assign v1 = {pcw1, adr1, memw1, irw1, res1, sa1, sb1, regw1, imm1, alu1, ill1, hlt1};

  multicycle_controller #(.ILLEGAL_TRAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
`ifdef MC_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(zero),
    .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(memw0), .IRWrite(irw0),
    .ResultSrc(res0), .ALUSrcA(sa0), .ALUSrcB(sb0), .RegWrite(regw0),
    .ImmSrc(imm0), .ALUControl(alu0), .illegal_o(ill0), .halted_o(hlt0)
  );

  multicycle_controller #(.ILLEGAL_TRAP(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef MC_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(zero),
    .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(memw1), .IRWrite(irw1),
    .ResultSrc(res1), .ALUSrcA(sa1), .ALUSrcB(sb1), .RegWrite(regw1),
    .ImmSrc(imm1), .ALUControl(alu1), .illegal_o(ill1), .halted_o(hlt1)
  );

  always #5 clk = ~clk;

  function automatic bit known(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == JL) || (o == BQ);
  endfunction

  function automatic int lat(input logic [6:0] o);
    if (o == LW) return 5;
    if (o == BQ) return 3;
    if (known(o)) return 4;
    return 2;
  endfunction

  // Arithmetic op an R/I instruction asks for: 000 add, 001 sub, 010 and, 011 or, 101 slt
  function automatic logic [2:0] func_alu(input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7);
    case (f3)
      3'b000:  return (o == RT && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected control vector for cycle c of an instruction; rst = reset held,
  // halt = trapping controller parked after an unknown opcode.
  function automatic logic [17:0] exp_vec(input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic z, input int c,
                                          input bit rst, input bit halt);
    logic pcw, adr, memw, irw, regw, ill, hlt;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu;
    pcw = 0; adr = 0; memw = 0; irw = 0; regw = 0; ill = 0; hlt = 0;
    res = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
    if (o == SW) imm = 2'b01;
    else if (o == BQ) imm = 2'b10;
    else if (o == JL) imm = 2'b11;
    else imm = 2'b00;
    if (rst) begin
      res = 2'b10; sb = 2'b10;
    end else if (halt) begin
      hlt = 1;
    end else if (c == 0) begin
      irw = 1; pcw = 1; sb = 2'b10; res = 2'b10;
    end else if (c == 1) begin
      sa = 2'b01; sb = 2'b01; ill = !known(o);
    end else if (o == LW || o == SW) begin
      if (c == 2) begin sa = 2'b10; sb = 2'b01; end
      else if (o == SW) begin adr = 1; memw = 1; end
      else if (c == 3) adr = 1;
      else begin res = 2'b01; regw = 1; end
    end else if (o == RT || o == IT) begin
      if (c == 2) begin
        sa = 2'b10; sb = (o == IT) ? 2'b01 : 2'b00; alu = func_alu(o, f3, f7);
      end else regw = 1;
    end else if (o == JL) begin
      if (c == 2) begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      else regw = 1;
    end else if (o == BQ) begin
      sa = 2'b10; alu = 3'b001; pcw = z;
    end
    return {pcw, adr, memw, irw, res, sa, sb, regw, imm, alu, ill, hlt};
  endfunction

  // Drives one instruction and checks dut0 each cycle; ncyc < 0 runs it fully.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int ncyc, input string tag);
    logic [17:0] e;
    int n;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    n = (ncyc < 0) ? lat(o) : ncyc;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      e = exp_vec(o, f3, f7, z, c, 0, 0);
      total++;
      if (v0 !== e) begin
        bad++;
        $display("FAIL %s cyc%0d got=%b want=%b", tag, c, v0, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [17:0] e;
    op = RT; funct3 = 3'b000; funct7b5 = 1'b1; zero = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    e = exp_vec(RT, 3'b000, 1'b1, 1'b0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (v0 !== e || v1 !== e) begin
        bad++;
        $display("FAIL reset_hold%0d got=%b/%b want=%b", i, v0, v1, e);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    run_instr(RT, 3'b000, 1'b1, 1'b0, -1, "reset_rsub");
  endtask

  task automatic test_lw();
    run_instr(LW, 3'($urandom), 1'($urandom), 1'($urandom), -1, "lw");
  endtask

  task automatic test_sw();
    run_instr(SW, 3'($urandom), 1'($urandom), 1'($urandom), -1, "sw");
  endtask

  task automatic test_beq();
    run_instr(BQ, 3'b000, 1'b0, 1'b1, -1, "beq_taken");
    run_instr(BQ, 3'b000, 1'b0, 1'b0, -1, "beq_not");
  endtask

  task automatic test_jal();
    run_instr(JL, 3'($urandom), 1'($urandom), 1'($urandom), -1, "jal");
  endtask

  // Reset arriving during MEMWB must drop RegWrite immediately.
  task automatic test_reset_mid();
    logic [17:0] e;
    run_instr(LW, 3'b010, 1'b0, 1'b0, 4, "mid_lw");
    rst_n = 1'b0;
    #1;
    e = exp_vec(LW, 3'b010, 1'b0, 1'b0, 0, 1, 0);
    total++;
    if (v0 !== e) begin
      bad++;
      $display("FAIL reset_mid got=%b want=%b", v0, e);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_instr(IT, 3'b110, 1'b1, 1'b0, -1, "after_mid");
  endtask

  task automatic test_illegal();
    logic [17:0] e0, e1;
    apply_reset();
    op = BAD; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      e0 = exp_vec(BAD, 3'b000, 1'b0, 1'b0, c % 2, 0, 0);
      e1 = exp_vec(BAD, 3'b000, 1'b0, 1'b0, c, 0, c >= 2);
      total++;
      if (v0 !== e0) begin
        bad++;
        $display("FAIL illegal_trap0 cyc%0d got=%b want=%b", c, v0, e0);
      end
      total++;
      if (v1 !== e1) begin
        bad++;
        $display("FAIL illegal_trap1 cyc%0d got=%b want=%b", c, v1, e1);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    e1 = exp_vec(BAD, 3'b000, 1'b0, 1'b0, 0, 1, 0);
    total++;
    if (v1 !== e1) begin
      bad++;
      $display("FAIL halt_reset got=%b want=%b", v1, e1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [6:0] ops [9];
    logic [17:0] e;
    ops = '{LW, SW, RT, IT, JL, BQ, BAD, 7'b0110111, 7'b1100111};
    for (int i = 0; i < 40; i++) begin
      run_instr(ops[$urandom_range(0, 8)], 3'($urandom), 1'($urandom), 1'($urandom), -1,
                "random");
    end
    @(negedge clk);
    e = exp_vec(op, funct3, funct7b5, zero, 0, 0, 0);
    total++;
    if (v0 !== e) begin
      bad++;
      $display("FAIL final_fetch got=%b want=%b", v0, e);
    end
    @(posedge clk); #1;
  endtask

`ifdef MC_MEM_WAIT_EN
  task automatic test_mem_wait();
    logic [17:0] e;
    apply_reset();
    op = RT; funct3 = 3'b111; funct7b5 = 1'b0; zero = 1'b0;
    mem_ready = 1'b0;
    e = exp_vec(RT, 3'b111, 1'b0, 1'b0, 0, 0, 0) & ~18'h24000;  // no IR/PC write yet
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (v0 !== e) begin
        bad++;
        $display("FAIL fetch_wait%0d got=%b want=%b", i, v0, e);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    run_instr(RT, 3'b111, 1'b0, 1'b0, -1, "after_wait");
  endtask
`endif

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_beq();
    test_jal();
    test_reset_mid();
    test_illegal();
    test_random();
`ifdef MC_MEM_WAIT_EN
    test_mem_wait();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
